// File: rtl/parity_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_scan_pkg
//  Description : Shared FSM state encoding and parity-mode constants for the
//                parity scan engine.
//  Revision    : 1.0  initial release
// ============================================================================
package parity_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    localparam logic c_PAR_EVEN = 1'b0;
    localparam logic c_PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : parity_calc
//  Description : Combinational parity check of one data word against its
//                stored parity bit, in even or odd mode.
//  Revision    : 1.0  initial release
// ============================================================================
module parity_calc
    import parity_scan_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    input  logic              mode,
    output logic              ok
);

    logic w_xor;

    always_comb begin
        w_xor = ^data;
        ok    = (mode == c_PAR_ODD) ? (w_xor != par) : (w_xor == par);
    end

endmodule
`default_nettype wire

// File: rtl/parity_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : parity_scan_engine
//  Description : Sequentially reads DEPTH words, checks each against its stored
//                parity bit and accumulates error statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module parity_scan_engine
    import parity_scan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int ODD_PARITY = 0
)(
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_par,
    output logic              busy,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic              done,
    output logic              err_flag,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic              c_MODE      = (ODD_PARITY != 0) ? c_PAR_ODD : c_PAR_EVEN;

    scan_state_e       r_state;
    logic              r_rd_d1;
    logic [ADDR_W-1:0] r_addr_d1;
    logic              w_ok;
    logic              w_kill;

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity_calc (
        .data (mem_data),
        .par  (mem_par),
        .mode (c_MODE),
        .ok   (w_ok)
    );

    // An abort drops every word still in the read pipeline.
    always_comb begin
        w_kill = abort && ((r_state == SCAN) || (r_state == DRAIN));
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state        <= IDLE;
            r_rd_d1        <= 1'b0;
            r_addr_d1      <= '0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            busy           <= 1'b0;
            chk_valid      <= 1'b0;
            chk_ok         <= 1'b0;
            done           <= 1'b0;
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done      <= 1'b0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            r_rd_d1   <= mem_rd && !w_kill;
            r_addr_d1 <= mem_addr;

            // Word read last cycle has its data on the bus now.
            if (r_rd_d1 && !w_kill) begin
                chk_valid <= 1'b1;
                chk_ok    <= w_ok;
                if (!w_ok) begin
                    err_flag <= 1'b1;
                    if (err_cnt < c_CNT_MAX) begin
                        err_cnt <= err_cnt + c_CNT_ONE;
                    end
                    if (!err_flag) begin
                        first_err_addr <= r_addr_d1;
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= SCAN;
                        busy           <= 1'b1;
                        mem_rd         <= 1'b1;
                        mem_addr       <= '0;
                        err_flag       <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                    end else if (mem_addr == c_LAST_ADDR) begin
                        r_state  <= DRAIN;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + c_ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    mem_rd  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_scan_engine
//  Description : Directed self-checking bench for parity_scan_engine.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parity_scan_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear, start_a, abort_a, start_o, start_4, zero;

    // default instance (even, DEPTH 16)
    logic       rd_a, busy_a, v_a, ok_a, done_a, ef_a, mp_a;
    logic [3:0] addr_a, fe_a;
    logic [4:0] ec_a;
    logic [7:0] md_a;
    // odd-parity instance
    logic       rd_o, busy_o, v_o, ok_o, done_o, ef_o, mp_o;
    logic [3:0] addr_o, fe_o;
    logic [4:0] ec_o;
    logic [7:0] md_o;
    // DEPTH 4 instance
    logic       rd_4, busy_4, v_4, ok_4, done_4, ef_4, mp_4;
    logic [1:0] addr_4, fe_4;
    logic [2:0] ec_4;
    logic [7:0] md_4;

    logic [7:0]  dat [16];
    logic [15:0] par_a, par_o;
    logic [3:0]  par_4;

    parity_scan_engine dut_a (
        .clk(clk), .clear(clear), .start(start_a), .abort(abort_a),
        .mem_rd(rd_a), .mem_addr(addr_a), .mem_data(md_a), .mem_par(mp_a),
        .busy(busy_a), .chk_valid(v_a), .chk_ok(ok_a), .done(done_a),
        .err_flag(ef_a), .err_cnt(ec_a), .first_err_addr(fe_a)
    );

    parity_scan_engine #(.ODD_PARITY(1)) dut_o (
        .clk(clk), .clear(clear), .start(start_o), .abort(zero),
        .mem_rd(rd_o), .mem_addr(addr_o), .mem_data(md_o), .mem_par(mp_o),
        .busy(busy_o), .chk_valid(v_o), .chk_ok(ok_o), .done(done_o),
        .err_flag(ef_o), .err_cnt(ec_o), .first_err_addr(fe_o)
    );

    parity_scan_engine #(.DEPTH(4)) dut_4 (
        .clk(clk), .clear(clear), .start(start_4), .abort(zero),
        .mem_rd(rd_4), .mem_addr(addr_4), .mem_data(md_4), .mem_par(mp_4),
        .busy(busy_4), .chk_valid(v_4), .chk_ok(ok_4), .done(done_4),
        .err_flag(ef_4), .err_cnt(ec_4), .first_err_addr(fe_4)
    );

    // Synchronous memories: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        md_a <= rd_a ? dat[addr_a] : 8'h00;
        mp_a <= rd_a ? par_a[addr_a] : 1'b1;
        md_o <= rd_o ? dat[addr_o] : 8'h00;
        mp_o <= rd_o ? par_o[addr_o] : 1'b0;
        md_4 <= rd_4 ? dat[{2'b00, addr_4}] : 8'h00;
        mp_4 <= rd_4 ? par_4[addr_4] : 1'b1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    int          nvalid, nrd, addr_bad, first_valid, done_cyc, ndone, abort_cyc;
    logic [15:0] okvec;

    // Pulse start on instance a (which=0) or o (which=1) and watch ncyc cycles.
    task automatic run(input int which, input int ncyc, input int abort_addr, input bit abort_w_start);
        logic       s_v, s_ok, s_done, s_rd;
        logic [3:0] s_addr;
        nvalid = 0; nrd = 0; addr_bad = 0; first_valid = -1;
        done_cyc = -1; ndone = 0; abort_cyc = -1; okvec = 16'h5A5A;
        if (which == 0) start_a = 1'b1; else start_o = 1'b1;
        abort_a = abort_w_start;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start_a = 1'b0; start_o = 1'b0; abort_a = 1'b0;
                if (which == 0) check("start_clears_cnt", ec_a, 0);
                if (abort_w_start) check("abort_start_busy", busy_a, 1);
            end
            if (which == 0) begin
                s_v = v_a; s_ok = ok_a; s_done = done_a; s_rd = rd_a; s_addr = addr_a;
            end else begin
                s_v = v_o; s_ok = ok_o; s_done = done_o; s_rd = rd_o; s_addr = addr_o;
            end
            if (s_rd) begin
                if (int'(s_addr) != nrd) addr_bad++;
                nrd++;
            end
            if (s_v) begin
                if (nvalid < 16) okvec[nvalid] = s_ok;
                if (first_valid < 0) first_valid = n;
                nvalid++;
            end
            if (s_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (abort_cyc >= 0 && n == abort_cyc + 1)
                check("abort_idle", {busy_a, rd_a}, 2'b00);
            if (abort_addr >= 0 && abort_cyc < 0 && s_rd && int'(s_addr) == abort_addr) begin
                abort_a   = 1'b1;
                abort_cyc = n;
            end else begin
                abort_a = 1'b0;
            end
        end
    endtask

    task automatic expect_scan(input string tag, input int which, input logic [15:0] exp_ok,
                               input int exp_cnt, input int exp_first, input bit exp_flag);
        check({tag, "_nvalid"}, nvalid, 16);
        check({tag, "_okvec"}, okvec, exp_ok);
        check({tag, "_done_cyc"}, done_cyc, 19);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_addr_seq"}, addr_bad, 0);
        check({tag, "_nrd"}, nrd, 16);
        check({tag, "_first_valid"}, first_valid, 3);
        if (which == 0) begin
            check({tag, "_err_cnt"}, ec_a, exp_cnt);
            check({tag, "_first_err"}, fe_a, exp_first);
            check({tag, "_err_flag"}, ef_a, exp_flag);
            check({tag, "_busy_end"}, busy_a, 0);
        end else begin
            check({tag, "_err_cnt"}, ec_o, exp_cnt);
            check({tag, "_first_err"}, fe_o, exp_first);
            check({tag, "_err_flag"}, ef_o, exp_flag);
            check({tag, "_busy_end"}, busy_o, 0);
        end
    endtask

    initial begin
        int nv4, nd4, d4_first, d4_second, bad4, nrd4;
        clear = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_o = 1'b0; start_4 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dat[i]   = 8'(i * 37 + 11);
            par_a[i] = ^dat[i];
            par_o[i] = ^dat[i];
        end
        for (int i = 0; i < 4; i++) par_4[i] = ^dat[i];

        @(posedge clk); #1;
        check("reset_outputs_a", {rd_a, addr_a, busy_a, v_a, ok_a, done_a, ef_a, ec_a, fe_a}, 0);
        check("reset_busy_o4", {busy_o, busy_4, rd_o, rd_4}, 0);
        clear = 1'b0;

        // clean scan, start on the first edge after reset release
        run(0, 22, -1, 1'b0);
        expect_scan("clean", 0, 16'hFFFF, 0, 0, 1'b0);

        // words 3 and 9 corrupted
        par_a[3] = ~par_a[3]; par_a[9] = ~par_a[9];
        run(0, 22, -1, 1'b0);
        expect_scan("bad3_9", 0, 16'hFDF7, 2, 3, 1'b1);
        par_a[3] = ~par_a[3]; par_a[9] = ~par_a[9];

        // abort at address 5 with words 1,3 (and in-flight 4) corrupted
        par_a[1] = ~par_a[1]; par_a[3] = ~par_a[3]; par_a[4] = ~par_a[4];
        run(0, 12, 5, 1'b0);
        check("abort_cyc", abort_cyc, 6);
        check("abort_nvalid", nvalid, 4);
        check("abort_no_done", ndone, 0);
        check("abort_err_cnt", ec_a, 2);
        check("abort_first_err", fe_a, 1);
        check("abort_err_flag", ef_a, 1);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("idle_abort_noeffect", {busy_a, ec_a, fe_a}, {1'b0, 5'd2, 4'd1});
        run(0, 22, -1, 1'b1);
        expect_scan("after_abort", 0, 16'hFFE5, 3, 1, 1'b1);
        par_a[1] = ~par_a[1]; par_a[4] = ~par_a[4];

        // clear mid-scan at address 7 (word 3 still corrupted)
        start_a = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        check("clr_at_addr7", {rd_a, addr_a, ec_a}, {1'b1, 4'd7, 5'd1});
        clear = 1'b1;
        #1;
        check("clr_immediate", {rd_a, addr_a, busy_a, v_a, ok_a, done_a, ef_a, ec_a, fe_a}, 0);
        @(posedge clk); #1;
        check("clr_held", {rd_a, addr_a, busy_a, v_a, ok_a, done_a, ef_a, ec_a, fe_a}, 0);
        clear = 1'b0;
        run(0, 22, -1, 1'b0);
        expect_scan("after_clr", 0, 16'hFFF7, 1, 3, 1'b1);

        // odd mode on even-parity memory: every word fails
        run(1, 22, -1, 1'b0);
        expect_scan("odd", 1, 16'h0000, 16, 0, 1'b1);

        // DEPTH 4 with start held high across the whole scan
        nv4 = 0; nd4 = 0; d4_first = -1; d4_second = -1; bad4 = 0; nrd4 = 0;
        start_4 = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk); #1;
            if (n == 7) check("d4_idle_at_done", busy_4, 0);
            if (n == 8) begin
                check("d4_restart", {busy_4, rd_4, addr_4}, {1'b1, 1'b1, 2'd0});
                start_4 = 1'b0;
            end
            if (rd_4) begin
                if (int'(addr_4) != (nrd4 % 4)) bad4++;
                nrd4++;
            end
            if (v_4) begin
                nv4++;
                if (!ok_4) bad4++;
            end
            if (done_4) begin
                nd4++;
                if (d4_first < 0) d4_first = n; else d4_second = n;
            end
        end
        check("d4_done_first", d4_first, 7);
        check("d4_done_second", d4_second, 14);
        check("d4_ndone", nd4, 2);
        check("d4_nvalid", nv4, 8);
        check("d4_addr_ok", bad4, 0);
        check("d4_err_cnt", {ec_4, ef_4}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
